// File: rtl/mpsoc_instr_mem_loader.sv
// Loads a little-endian byte stream into a processor instruction memory,
// then reads every word back and compares checksums before releasing the CPU.
module mpsoc_instr_mem_loader #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              cpu_reset_req,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_CAPTURE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_offset;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word;
    logic [31:0]       r_wsum;
    logic [31:0]       r_rsum;
    logic              r_error;

    logic              w_count_ok;
    logic [ADDR_W:0]   w_offset_inc;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;
    logic              w_sum_bad;
    logic              w_start_idle;

    // A zero or oversized count is rejected before any memory access.
    assign w_count_ok   = (word_count != '0) && (word_count <= L_DEPTH);
    assign w_offset_inc = r_offset + L_ONE;
    assign w_last       = (w_offset_inc == r_count);
    // Address arithmetic wraps naturally at the port width.
    assign w_addr       = r_base + r_offset[ADDR_W-1:0];
    assign w_sum_bad    = (r_rsum != r_wsum);
    assign w_start_idle = (r_state == S_IDLE) && start;

    // Outputs decode the registered state; reset forces them quiet at once.
    assign in_ready       = !reset && (r_state == S_COLLECT);
    assign mem_chipselect = !reset && ((r_state == S_WRITE) ||
                                       (r_state == S_RD_ISSUE));
    assign mem_write      = !reset && (r_state == S_WRITE);
    assign mem_address    = reset ? '0 : w_addr;
    assign mem_writedata  = reset ? '0 : r_word;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign busy           = !reset && (r_state != S_IDLE);
    assign cpu_reset_req  = busy;
    assign done           = !reset && (r_state == S_DONE);
    // Sticky flag: a new start hides the old failure in its own cycle,
    // and a checksum mismatch is already visible during the done pulse.
    assign error          = !reset && !w_start_idle &&
                            (r_error || ((r_state == S_DONE) && w_sum_bad));

    // Load sequencer: collect bytes, write words, read back, compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_count    <= '0;
            r_offset   <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_wsum     <= '0;
            r_rsum     <= '0;
            r_error    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_offset   <= '0;
                        r_byte_idx <= '0;
                        r_wsum     <= '0;
                        r_rsum     <= '0;
                        if (w_count_ok) begin
                            r_base  <= base_addr;
                            r_count <= word_count;
                            r_error <= 1'b0;
                            r_state <= S_COLLECT;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_wsum <= r_wsum + r_word;
                    if (w_last) begin
                        r_offset <= '0;
                        r_state  <= S_RD_ISSUE;
                    end else begin
                        r_offset <= w_offset_inc;
                        r_state  <= S_COLLECT;
                    end
                end
                S_RD_ISSUE: begin
                    r_state <= S_RD_CAPTURE;
                end
                S_RD_CAPTURE: begin
                    r_rsum   <= r_rsum + mem_readdata;
                    r_offset <= w_offset_inc;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RD_ISSUE;
                    end
                end
                S_DONE: begin
                    if (w_sum_bad) begin
                        r_error <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpsoc_instr_mem_loader.sv
// Bench for mpsoc_instr_mem_loader: memory model, write scoreboard,
// and one task per scenario.
module tb_mpsoc_instr_mem_loader;

    localparam int AW    = 14;
    localparam int DEPTH = 16384;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic          cpu_reset_req;
    logic          busy;
    logic          done;
    logic          error;

    mpsoc_instr_mem_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .cpu_reset_req  (cpu_reset_req),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    logic [31:0]   mem [DEPTH];
    bit            corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            mem[mem_address] <= mem_writedata;
        if (mem_chipselect && !mem_write)
            mem_readdata <= mem[mem_address] ^
                ((corrupt_en && mem_address == corrupt_addr) ? 32'h1 : 32'h0);
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t wq[$];
    wr_t mon_e;
    int  n_vec   = 0;
    int  n_err   = 0;
    int  n_bytes = 0;

    always @(negedge clk) begin
        if (reset) begin
            n_bytes = 0;
        end else begin
            if (in_valid && in_ready) n_bytes++;
            if (mem_chipselect && mem_write) begin
                n_vec++;
                if (wq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write addr=%h data=%h",
                             mem_address, mem_writedata);
                end else begin
                    mon_e = wq.pop_front();
                    if (mem_address !== mon_e.a ||
                        mem_writedata !== mon_e.d) begin
                        n_err++;
                        $display("FAIL write got %h@%h exp %h@%h",
                                 mem_writedata, mem_address, mon_e.d, mon_e.a);
                    end
                end
                n_vec++;
                if (n_bytes !== 4) begin
                    n_err++;
                    $display("FAIL bytes_per_word got %0d exp 4", n_bytes);
                end
                n_bytes = 0;
                n_vec++;
                if (mem_byteenable !== 4'hF) begin
                    n_err++;
                    $display("FAIL byteenable got %h exp f", mem_byteenable);
                end
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] b, input logic [31:0] w[$]);
        foreach (w[k]) wq.push_back('{a: b + AW'(k), d: w[k]});
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] w[$], input bit gappy,
                              input int inject_at);
        logic [7:0] b[$];
        int i = 0;
        int cyc = 0;
        bit tog = 1'b1;
        foreach (w[k]) for (int j = 0; j < 4; j++) b.push_back(w[k][8*j +: 8]);
        while (i < b.size() && cyc < 2000) begin
            in_data  = b[i];
            in_valid = gappy ? tog : 1'b1;
            start    = (cyc == inject_at);
            if (start) begin
                base_addr  = 14'd100;
                word_count = 15'd1;
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            tog = !tog;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        n_vec++;
        if (i != b.size()) begin
            n_err++;
            $display("FAIL send_timeout accepted %0d exp %0d", i, b.size());
        end
    endtask

    task automatic wait_done(output bit seen, output logic err);
        int cyc = 0;
        seen = 1'b0;
        err  = 1'b0;
        while (!seen && cyc < 1000) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                err  = error;
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_ready, mem_chipselect, mem_write, busy, done, error,
             cpu_reset_req} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b exp 0", {in_ready,
                     mem_chipselect, mem_write, busy, done, error,
                     cpu_reset_req});
        end
        n_vec++;
        if (mem_address !== '0 || mem_writedata !== '0) begin
            n_err++;
            $display("FAIL reset_bus got a=%h d=%h exp 0",
                     mem_address, mem_writedata);
        end
        n_vec++;
        if (mem_clken !== 1'b1) begin
            n_err++;
            $display("FAIL reset_clken got %b exp 1", mem_clken);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet got rdy=%b busy=%b exp 0", in_ready, busy);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] w[$] = '{32'h12345678, 32'hDEADBEEF};
        bit seen;
        logic err;
        push_exp(14'd0, w);
        do_start(14'd0, 15'd2);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_reset_req !== 1'b1) begin
            n_err++;
            $display("FAIL basic_collect got rdy=%b busy=%b crr=%b exp 1",
                     in_ready, busy, cpu_reset_req);
        end
        @(posedge clk); #1;
        send_words(w, 1'b0, -1);
        wait_done(seen, err);
        n_vec++;
        if (seen !== 1'b1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done got done=%b err=%b exp 1/0", seen, err);
        end
        n_vec++;
        if (wq.size() != 0) begin
            n_err++;
            $display("FAIL basic_writes got %0d pending exp 0", wq.size());
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || cpu_reset_req !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after got busy=%b crr=%b done=%b exp 0",
                     busy, cpu_reset_req, done);
        end
        n_vec++;
        if (mem[0] !== 32'h12345678 || mem[1] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL basic_mem got %h %h exp 12345678 deadbeef",
                     mem[0], mem[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [31:0] w[$] = '{32'hCAFE0001, 32'hCAFE0002};
        bit seen;
        logic err;
        push_exp(14'd16383, w);
        do_start(14'd16383, 15'd2);
        send_words(w, 1'b0, -1);
        wait_done(seen, err);
        n_vec++;
        if (seen !== 1'b1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_done got done=%b err=%b exp 1/0", seen, err);
        end
        n_vec++;
        if (mem[16383] !== 32'hCAFE0001 || mem[0] !== 32'hCAFE0002) begin
            n_err++;
            $display("FAIL wrap_mem got %h %h exp cafe0001 cafe0002",
                     mem[16383], mem[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bad_count();
        logic [AW:0] cnts[2] = '{15'd0, 15'd16385};
        foreach (cnts[k]) begin
            do_start(14'd5, cnts[k]);
            @(negedge clk);
            n_vec++;
            if (done !== 1'b1 || error !== 1'b1 || mem_write !== 1'b0) begin
                n_err++;
                $display("FAIL bad_count%0d got done=%b err=%b wr=%b exp 1/1/0",
                         k, done, error, mem_write);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b1) begin
                n_err++;
                $display("FAIL bad_after%0d got done=%b busy=%b err=%b exp 0/0/1",
                         k, done, busy, error);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_corrupt();
        logic [31:0] w[$] = '{32'h00000010, 32'h00000020, 32'h00000030};
        logic [31:0] g[$] = '{32'h0BADF00D};
        bit seen;
        logic err;
        corrupt_en   = 1'b1;
        corrupt_addr = 14'd201;
        push_exp(14'd200, w);
        do_start(14'd200, 15'd3);
        send_words(w, 1'b0, -1);
        wait_done(seen, err);
        n_vec++;
        if (seen !== 1'b1 || err !== 1'b1) begin
            n_err++;
            $display("FAIL corrupt_done got done=%b err=%b exp 1/1", seen, err);
        end
        @(negedge clk);
        n_vec++;
        if (error !== 1'b1) begin
            n_err++;
            $display("FAIL corrupt_sticky got %b exp 1", error);
        end
        corrupt_en = 1'b0;
        @(posedge clk); #1;
        push_exp(14'd300, g);
        do_start(14'd300, 15'd1);
        @(negedge clk);
        n_vec++;
        if (error !== 1'b0) begin
            n_err++;
            $display("FAIL corrupt_clear got %b exp 0", error);
        end
        @(posedge clk); #1;
        send_words(g, 1'b0, -1);
        wait_done(seen, err);
        n_vec++;
        if (seen !== 1'b1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL good_after_bad got done=%b err=%b exp 1/0", seen, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gappy();
        logic [31:0] w[$] = '{32'hA1B2C3D4, 32'h01020304, 32'hFFEEDDCC};
        bit seen;
        logic err;
        push_exp(14'd50, w);
        do_start(14'd50, 15'd3);
        send_words(w, 1'b1, 5);
        wait_done(seen, err);
        n_vec++;
        if (seen !== 1'b1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL gappy_done got done=%b err=%b exp 1/0", seen, err);
        end
        n_vec++;
        if (wq.size() != 0) begin
            n_err++;
            $display("FAIL gappy_writes got %0d pending exp 0", wq.size());
        end
        n_vec++;
        if (mem[52] !== 32'hFFEEDDCC) begin
            n_err++;
            $display("FAIL gappy_mem got %h exp ffeeddcc", mem[52]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [31:0] w[$] = '{32'h11111111, 32'h22222222};
        int cyc = 0;
        bit hit = 1'b0;
        bit saw_done = 1'b0;
        push_exp(14'd400, w);
        do_start(14'd400, 15'd2);
        send_words(w, 1'b0, -1);
        while (!hit && cyc < 50) begin
            @(negedge clk);
            if (mem_chipselect && !mem_write) hit = 1'b1;
            cyc++;
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL abort_rd_issue got none exp seen");
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || mem_chipselect !== 1'b0 || cpu_reset_req !== 1'b0) begin
            n_err++;
            $display("FAIL abort_during got busy=%b cs=%b crr=%b exp 0",
                     busy, mem_chipselect, cpu_reset_req);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || cpu_reset_req !== 1'b0 || done !== 1'b0 ||
            mem_address !== '0) begin
            n_err++;
            $display("FAIL abort_after got busy=%b crr=%b done=%b a=%h exp 0",
                     busy, cpu_reset_req, done, mem_address);
        end
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL abort_no_done got pulse exp none");
        end
        n_vec++;
        if (mem[400] !== 32'h11111111 || mem[401] !== 32'h22222222) begin
            n_err++;
            $display("FAIL abort_mem got %h %h exp 11111111 22222222",
                     mem[400], mem[401]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_wrap();
        test_bad_count();
        test_corrupt();
        test_gappy();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
